// File: rtl/decoder_strobe_seq.sv
// Buffered binary-to-one-hot decoder. It queues {none, index} entries in a small
// circular FIFO and presents each decoded pattern on out for HOLD cycles.
module decoder_strobe_seq #(
   parameter int IN_W  = 3,
   parameter int DEPTH = 4,
   parameter int HOLD  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IN_W-1:0]        in,
   input  logic                   in_none,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [(2**IN_W)-1:0]   out,
   output logic                   out_valid,
   output logic                   out_done,
   output logic [$clog2(DEPTH):0] level
);
   localparam int OUT_W = 2**IN_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   logic [IN_W:0]    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   state_t           state;
   logic             push;
   logic             pop;
   logic [IN_W:0]    head;

   function automatic logic [OUT_W-1:0] decode(input logic [IN_W:0] entry);
      decode = entry[IN_W] ? '0 : (OUT_W'(1) << entry[IN_W-1:0]);
   endfunction

   // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
   assign in_ready = (level != LVL_W'(DEPTH));
   assign push     = in_valid && in_ready;
   // The counter rests at zero in IDLE, so one term covers both the first pop and reloads.
   assign pop      = (level != '0) && ((state == ST_IDLE) || (cnt == '0));
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_none, in};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         out_done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  state     <= ST_HOLD;
                  cnt       <= CNT_W'(HOLD - 1);
                  out       <= decode(head);
                  out_valid <= 1'b1;
                  out_done  <= (HOLD == 1);
               end else begin
                  out       <= '0;
                  out_valid <= 1'b0;
                  out_done  <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (cnt != '0) begin
                  cnt      <= cnt - CNT_W'(1);
                  out_done <= (cnt == CNT_W'(1));
               end else if (pop) begin
                  cnt       <= CNT_W'(HOLD - 1);
                  out       <= decode(head);
                  out_valid <= 1'b1;
                  out_done  <= (HOLD == 1);
               end else begin
                  state     <= ST_IDLE;
                  out       <= '0;
                  out_valid <= 1'b0;
                  out_done  <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               cnt       <= '0;
               out       <= '0;
               out_valid <= 1'b0;
               out_done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/decoder_strobe_seq.md
Name: decoder_strobe_seq

Overview:
Buffered binary-to-one-hot decoder. It is the inverse of the team's 8-to-3 priority encoder. It accepts encoded indices over a valid/ready handshake, queues them in a small FIFO, and drives each decoded one-hot pattern on `out` for a fixed number of cycles. Typical use: replaying encoder results onto LED or strobe lines, or driving a one-hot select bus from a stream of indices.

Parameters:
- IN_W, 3: width of encoded index. Output width is 2**IN_W.
- DEPTH, 4: FIFO entries. Power of two, >= 2.
- HOLD, 4: cycles each decoded pattern is held on `out`. >= 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in, input, IN_W: encoded index.
- in_none, input, 1: marks "no bit set". Decodes to all-zeros regardless of `in`.
- in_valid, input, 1: `in`/`in_none` are valid.
- in_ready, output, 1: block can accept an entry.
- out, output, 2**IN_W: decoded one-hot pattern, registered.
- out_valid, output, 1: `out` holds a pattern being presented.
- out_done, output, 1: single-cycle pulse on the last hold cycle of each entry.
- level, output, clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (async, `rst_n`=0):
  - `out`=0, `out_valid`=0, `out_done`=0, `level`=0, `in_ready`=1 once the FIFO is cleared.
  - FSM goes to IDLE and the hold counter goes to 0.
  - Takes effect immediately, mid-hold included. In-flight and queued entries are discarded.
- Accept:
  - An entry {`in_none`, `in`} is pushed on a rising edge where `in_valid`=1 and `in_ready`=1.
  - `in_ready` = (`level` != DEPTH). It depends only on occupancy, so there is no push-through when full, even if a pop happens that cycle.
  - `in_valid` with `in_ready`=0 is ignored and the source must hold its data.
- FIFO:
  - Circular buffer with `log2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH.
  - Push and pop on the same edge leave `level` unchanged.
  - `level` never exceeds DEPTH and never underflows.
- Decode:
  - `out` = 1 << `in` when `in_none`=0.
  - `out` = 0 when `in_none`=1. `out_valid` is still 1 for the full hold period.
- FSM, states IDLE and HOLD:
  - IDLE:
    - Drives `out`=0, `out_valid`=0.
    - If `level`>0, pops the head at the next edge, loads the decoded `out`, sets the counter to HOLD-1, and goes to HOLD.
  - HOLD:
    - Drives `out_valid`=1, `out` stable; the counter decrements each edge.
    - `out_done`=1 during the cycle where the counter = 0.
    - At that edge, if `level`>0 (including an entry pushed on that same edge's preceding cycle), it pops the next entry and stays in HOLD with no gap cycle. Otherwise it goes to IDLE with `out`=0.
- Latency:
  - An entry accepted at edge t into an empty, idle block gives `out_valid`=1 from edge t+1.
  - Each entry occupies exactly HOLD cycles of `out_valid`.
  - N back-to-back queued entries produce N*HOLD contiguous valid cycles.
- HOLD=1: each entry is valid for one cycle, and `out_done` is high on every valid cycle.
- Indices are always in range; all 2**IN_W codes are legal. There are no X outputs after reset.

Test Plan:
- Reset then idle:
  - Stimulus: `rst_n` low 3 cycles, release, `in_valid`=0.
  - Required: `out`=8'h00, `out_valid`=0, `in_ready`=1, `level`=0 indefinitely.
- Single entry:
  - Stimulus: push `in`=3'd3, `in_none`=0 at edge t.
  - Required: `out`=8'b0000_1000 with `out_valid`=1 on edges t+1..t+4, `out_done` only in the 4th cycle, then `out`=0 and `out_valid`=0.
- Back-to-back and none:
  - Stimulus: push 0, then `in_none`=1, then 7 on consecutive cycles.
  - Required: 12 contiguous valid cycles of 8'h01 x4, 8'h00 x4, 8'h80 x4, and exactly 3 `out_done` pulses.
- Full and wrap:
  - Stimulus: push 6 entries (1..6) with `in_valid` held high.
  - Required:
    - `level` reaches 4 and `in_ready` drops.
    - Entries are retained, none lost or duplicated.
    - All 6 patterns appear in order 8'h02..8'h40 across pointer wrap.
    - `level` returns to 0.
- Reset mid-hold:
  - Stimulus: push 5, then 2. Assert `rst_n`=0 asynchronously in the 2nd hold cycle, between clock edges.
  - Required:
    - `out`=0, `out_valid`=0, `level`=0 immediately.
    - After release, nothing is replayed.
- HOLD=1 variant:
  - Stimulus: push 0..7 continuously.
  - Required: `out` walks 8'h01..8'h80 one per cycle, with `out_done`=1 on every valid cycle.
